spi_ram_cmd_sequencer: RTL and testbench

Host-side command sequencer directly upstream of the SPI master/slave/RAM wrapper. It accepts single read or write requests over a valid/ready interface and expands each into the two 10-bit SPI frames the wrapper expects: address frame, then data frame. It pulses the wrapper's start, waits for done, captures read data, and returns one response per request. A timeout guards against a hung transfer.

---
 rtl/spi_ram_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_spi_ram_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_cmd_sequencer.sv
// spi_ram_cmd_sequencer
//
// Host-side command sequencer sitting in front of the SPI/RAM wrapper. Each
// accepted request is turned into two 10-bit frames, an address frame (A)
// followed by a data frame (B). The sequencer pulses the wrapper start, waits
// for done, captures read data and returns one response per request. A
// per-frame timeout aborts a hung transfer and reports an error.
//
// Frame encoding ([9:8] = command):
//   write : A = {2'b00, addr}  B = {2'b01, wdata}
//   read  : A = {2'b10, addr}  B = {2'b11, 8'h00}
//
// Ports:
//   i_spi_ram_seq_clk        system clock, shared with the wrapper
//   i_spi_ram_seq_rst        synchronous active-high reset
//   i_/o_spi_ram_seq_req_*   request channel (valid/ready, write, addr, wdata)
//   o_/i_spi_ram_seq_rsp_*   response channel (valid/ready, rdata, err)
//   o_spi_ram_seq_spi_data   frame presented to the wrapper data_in
//   o_spi_ram_seq_spi_start  one-cycle start pulse to the wrapper
//   i_spi_ram_seq_spi_done   wrapper done pulse
//   i_spi_ram_seq_spi_busy   wrapper busy
//   i_spi_ram_seq_spi_rdata  wrapper data_out
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles waiting for done per frame (1..65535)
//   GAP_CYCLES      idle cycles between frame A done and frame B start (0..15)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request, spi_data = 0
// A_START  | frame A on spi_data, start pulses once wrapper is not busy
// A_WAIT   | waiting for frame A done, timeout counter running
// GAP      | inter-frame idle time, frame A still on spi_data
// B_START  | frame B on spi_data, start pulses once wrapper is not busy
// B_WAIT   | waiting for frame B done, read data captured on done
// RESP     | response held until the host accepts it

module spi_ram_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned GAP_CYCLES     = 2
) (
   input  logic       i_spi_ram_seq_clk,
   input  logic       i_spi_ram_seq_rst,
   input  logic       i_spi_ram_seq_req_valid,
   output logic       o_spi_ram_seq_req_ready,
   input  logic       i_spi_ram_seq_req_write,
   input  logic [7:0] i_spi_ram_seq_req_addr,
   input  logic [7:0] i_spi_ram_seq_req_wdata,
   output logic       o_spi_ram_seq_rsp_valid,
   input  logic       i_spi_ram_seq_rsp_ready,
   output logic [7:0] o_spi_ram_seq_rsp_rdata,
   output logic       o_spi_ram_seq_rsp_err,
   output logic [9:0] o_spi_ram_seq_spi_data,
   output logic       o_spi_ram_seq_spi_start,
   input  logic       i_spi_ram_seq_spi_done,
   input  logic       i_spi_ram_seq_spi_busy,
   input  logic [7:0] i_spi_ram_seq_spi_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_A_START,
      S_A_WAIT,
      S_GAP,
      S_B_START,
      S_B_WAIT,
      S_RESP
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t      state_q;
   logic        write_q;
   logic [7:0]  wdata_q;
   logic [9:0]  spi_data_q;
   logic [15:0] tmo_q;
   logic [3:0]  gap_q;
   logic        rsp_valid_q;
   logic [7:0]  rsp_rdata_q;
   logic        rsp_err_q;
   logic [9:0]  frame_b;

   assign frame_b = write_q ? {2'b01, wdata_q} : 10'h300;

   // Ready is gated by reset so it reads 0 while reset is applied and 1 in
   // the first cycle after it.
   assign o_spi_ram_seq_req_ready = (state_q == S_IDLE) && !i_spi_ram_seq_rst;

   // Start depends on the live busy level so the pulse lands in the first
   // cycle the wrapper is free, and in the cycle right after the handshake.
   assign o_spi_ram_seq_spi_start = ((state_q == S_A_START) || (state_q == S_B_START))
                                    && !i_spi_ram_seq_spi_busy;

   assign o_spi_ram_seq_spi_data  = spi_data_q;
   assign o_spi_ram_seq_rsp_valid = rsp_valid_q;
   assign o_spi_ram_seq_rsp_rdata = rsp_rdata_q;
   assign o_spi_ram_seq_rsp_err   = rsp_err_q;

   always_ff @(posedge i_spi_ram_seq_clk) begin
      if (i_spi_ram_seq_rst) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         wdata_q     <= 8'h00;
         spi_data_q  <= 10'h000;
         tmo_q       <= 16'h0000;
         gap_q       <= 4'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_spi_ram_seq_req_valid) begin
                  write_q    <= i_spi_ram_seq_req_write;
                  wdata_q    <= i_spi_ram_seq_req_wdata;
                  spi_data_q <= i_spi_ram_seq_req_write ? {2'b00, i_spi_ram_seq_req_addr}
                                                        : {2'b10, i_spi_ram_seq_req_addr};
                  state_q    <= S_A_START;
               end
            end

            S_A_START: begin
               if (!i_spi_ram_seq_spi_busy) begin
                  tmo_q   <= 16'h0000;
                  state_q <= S_A_WAIT;
               end
            end

            S_A_WAIT: begin
               // done in the last allowed cycle still counts as success
               if (i_spi_ram_seq_spi_done) begin
                  if (GAP_CYCLES == 0) begin
                     spi_data_q <= frame_b;
                     state_q    <= S_B_START;
                  end else begin
                     gap_q   <= GAP_LOAD;
                     state_q <= S_GAP;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 8'h00;
                  state_q     <= S_RESP;
               end else if (tmo_q != 16'hFFFF) begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end

            S_GAP: begin
               if (gap_q == 4'h0) begin
                  spi_data_q <= frame_b;
                  state_q    <= S_B_START;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end

            S_B_START: begin
               if (!i_spi_ram_seq_spi_busy) begin
                  tmo_q   <= 16'h0000;
                  state_q <= S_B_WAIT;
               end
            end

            S_B_WAIT: begin
               if (i_spi_ram_seq_spi_done) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= write_q ? 8'h00 : i_spi_ram_seq_spi_rdata;
                  state_q     <= S_RESP;
               end else if (tmo_q == TMO_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 8'h00;
                  state_q     <= S_RESP;
               end else if (tmo_q != 16'hFFFF) begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end

            S_RESP: begin
               if (i_spi_ram_seq_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 8'h00;
                  rsp_err_q   <= 1'b0;
                  spi_data_q  <= 10'h000;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_cmd_sequencer.sv
// Directed testbench for spi_ram_cmd_sequencer (TIMEOUT_CYCLES = 8,
// GAP_CYCLES = 2). Inputs are driven and outputs sampled on the falling edge.

module tb_spi_ram_cmd_sequencer;

   localparam int GAP = 2;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_ready = 1'b0;
   logic       spi_done = 1'b0;
   logic       spi_busy = 1'b0;
   logic [7:0] spi_rdata = 8'h00;

   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [9:0] spi_data;
   logic       spi_start;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   spi_ram_cmd_sequencer #(
      .TIMEOUT_CYCLES(TMO),
      .GAP_CYCLES    (GAP)
   ) dut (
      .i_spi_ram_seq_clk      (clk),
      .i_spi_ram_seq_rst      (rst),
      .i_spi_ram_seq_req_valid(req_valid),
      .o_spi_ram_seq_req_ready(req_ready),
      .i_spi_ram_seq_req_write(req_write),
      .i_spi_ram_seq_req_addr (req_addr),
      .i_spi_ram_seq_req_wdata(req_wdata),
      .o_spi_ram_seq_rsp_valid(rsp_valid),
      .i_spi_ram_seq_rsp_ready(rsp_ready),
      .o_spi_ram_seq_rsp_rdata(rsp_rdata),
      .o_spi_ram_seq_rsp_err  (rsp_err),
      .o_spi_ram_seq_spi_data (spi_data),
      .o_spi_ram_seq_spi_start(spi_start),
      .i_spi_ram_seq_spi_done (spi_done),
      .i_spi_ram_seq_spi_busy (spi_busy),
      .i_spi_ram_seq_spi_rdata(spi_rdata)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full two-frame transfer with an idle wrapper. wait_a = extra A_WAIT
   // cycles before done; hold = cycles the response is left unaccepted.
   task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rd,
                       input int wait_a, input int hold);
      logic [9:0] fa;
      logic [9:0] fb;
      logic [7:0] exp_rd;
      fa     = wr ? {2'b00, addr}  : {2'b10, addr};
      fb     = wr ? {2'b01, wdata} : 10'h300;
      exp_rd = wr ? 8'h00 : rd;

      chk({tag, " idle ready"}, 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      step();
      // scramble request inputs; the transfer must not follow them
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      chk({tag, " A start"}, 32'(spi_start), 32'(1));
      chk({tag, " A frame"}, 32'(spi_data), 32'(fa));
      chk({tag, " busy ready"}, 32'(req_ready), 32'(0));
      step();
      chk({tag, " A start once"}, 32'(spi_start), 32'(0));
      repeat (wait_a) step();
      spi_done = 1'b1;
      spi_rdata = 8'hEE;
      step();
      spi_done = 1'b0;
      for (int i = 0; i < GAP; i++) begin
         chk({tag, " gap start"}, 32'(spi_start), 32'(0));
         chk({tag, " gap frame"}, 32'(spi_data), 32'(fa));
         step();
      end
      chk({tag, " B start"}, 32'(spi_start), 32'(1));
      chk({tag, " B frame"}, 32'(spi_data), 32'(fb));
      step();
      chk({tag, " B start once"}, 32'(spi_start), 32'(0));
      spi_rdata = rd;
      spi_done  = 1'b1;
      step();
      spi_done  = 1'b0;
      spi_rdata = 8'h00;
      chk({tag, " rsp valid"}, 32'(rsp_valid), 32'(1));
      chk({tag, " rsp rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      chk({tag, " rsp err"}, 32'(rsp_err), 32'(0));
      chk({tag, " rsp frame"}, 32'(spi_data), 32'(fb));
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, " hold valid"}, 32'(rsp_valid), 32'(1));
         chk({tag, " hold rdata"}, 32'(rsp_rdata), 32'(exp_rd));
         chk({tag, " hold ready"}, 32'(req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, " post valid"}, 32'(rsp_valid), 32'(0));
      chk({tag, " post rdata"}, 32'(rsp_rdata), 32'(0));
      chk({tag, " post ready"}, 32'(req_ready), 32'(1));
      chk({tag, " post frame"}, 32'(spi_data), 32'(0));
   endtask

   initial begin
      // reset
      @(negedge clk);
      step();
      chk("rst ready", 32'(req_ready), 32'(0));
      chk("rst valid", 32'(rsp_valid), 32'(0));
      chk("rst rdata", 32'(rsp_rdata), 32'(0));
      chk("rst err", 32'(rsp_err), 32'(0));
      chk("rst data", 32'(spi_data), 32'(0));
      chk("rst start", 32'(spi_start), 32'(0));
      rst = 1'b0;
      step();
      chk("post rst ready", 32'(req_ready), 32'(1));

      // write then read back, done on the last cycle before timeout
      xfer("wr3c", 1'b1, 8'h3C, 8'hA5, 8'h00, 2, 0);
      xfer("rd3c", 1'b0, 8'h3C, 8'h00, 8'hA5, TMO - 1, 0);

      // spurious done in IDLE is ignored
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      chk("idle done ready", 32'(req_ready), 32'(1));
      chk("idle done start", 32'(spi_start), 32'(0));

      // wrapper busy for 20 cycles after the request
      spi_busy  = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h10;
      req_wdata = 8'h5A;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 19; i++) begin
         chk("busy no start", 32'(spi_start), 32'(0));
         chk("busy frame", 32'(spi_data), 32'(10'h010));
         step();
      end
      chk("busy last", 32'(spi_start), 32'(0));
      spi_busy = 1'b0;
      #1;
      chk("busy fall start", 32'(spi_start), 32'(1));
      step();
      chk("busy A_WAIT", 32'(spi_start), 32'(0));
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      step();
      step();
      chk("busy B start", 32'(spi_start), 32'(1));
      chk("busy B frame", 32'(spi_data), 32'(10'h15A));
      step();
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      chk("busy rsp valid", 32'(rsp_valid), 32'(1));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("busy done ready", 32'(req_ready), 32'(1));

      // timeout on frame A, response held for 5 cycles
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h55;
      step();
      req_valid = 1'b0;
      chk("tmo start", 32'(spi_start), 32'(1));
      step();
      chk("tmo w1 valid", 32'(rsp_valid), 32'(0));
      for (int i = 0; i < TMO - 1; i++) begin
         step();
         chk("tmo wait valid", 32'(rsp_valid), 32'(0));
         chk("tmo wait start", 32'(spi_start), 32'(0));
      end
      step();
      chk("tmo rsp valid", 32'(rsp_valid), 32'(1));
      chk("tmo rsp err", 32'(rsp_err), 32'(1));
      chk("tmo rsp rdata", 32'(rsp_rdata), 32'(0));
      chk("tmo no B", 32'(spi_start), 32'(0));
      for (int i = 0; i < 5; i++) begin
         spi_done = (i == 2);
         step();
         chk("tmo hold valid", 32'(rsp_valid), 32'(1));
         chk("tmo hold err", 32'(rsp_err), 32'(1));
         chk("tmo hold ready", 32'(req_ready), 32'(0));
         chk("tmo hold start", 32'(spi_start), 32'(0));
      end
      spi_done  = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("tmo exit err", 32'(rsp_err), 32'(0));
      chk("tmo exit ready", 32'(req_ready), 32'(1));

      // read with response back-pressure
      xfer("rdhold", 1'b0, 8'h3C, 8'h00, 8'hA5, 0, 5);

      // reset in the middle of A_WAIT
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h20;
      req_wdata = 8'h11;
      step();
      req_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("mid rst ready", 32'(req_ready), 32'(0));
      chk("mid rst valid", 32'(rsp_valid), 32'(0));
      chk("mid rst data", 32'(spi_data), 32'(0));
      chk("mid rst start", 32'(spi_start), 32'(0));
      rst = 1'b0;
      #1;
      chk("mid rst release", 32'(req_ready), 32'(1));
      step();
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      chk("mid rst no rsp", 32'(rsp_valid), 32'(0));

      xfer("after rst", 1'b0, 8'h3C, 8'h00, 8'h96, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
